// File: rtl/footies_pkg.sv
// Shared game definitions: character FSM states,
// controller states, coordinate width.
package footies_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [2:0] {
    IDLE            = 3'd0,
    MOVE_FWD        = 3'd1,
    MOVE_BACK       = 3'd2,
    ATTACK_START    = 3'd3,
    ATTACK_ACTIVE   = 3'd4,
    ATTACK_RECOVERY = 3'd5,
    HITSTUN         = 3'd6,
    BLOCK           = 3'd7
  } char_state_e;

  typedef enum logic [1:0] {
    AI_WAIT     = 2'd0,
    AI_DECIDE   = 2'd1,
    AI_ACT      = 2'd2,
    AI_COOLDOWN = 2'd3
  } ai_state_e;

  // Distance from opponent to self; crossover
  // (self left of opponent) saturates to 0.
  function automatic logic [COORD_W-1:0] sat_dist(
    input logic [COORD_W-1:0] self_x,
    input logic [COORD_W-1:0] opp_x
  );
    if (self_x >= opp_x)
      return self_x - opp_x;
    return '0;
  endfunction

endpackage

// File: rtl/cpu_opponent_if.sv
// Character-2 command bus: observed positions/states in,
// one-hot move/attack commands and debug state out.
interface cpu_opponent_if;
  import footies_pkg::*;

  logic               enable;
  logic [COORD_W-1:0] opp_x;
  logic [2:0]         opp_state;
  logic [COORD_W-1:0] self_x;
  logic [2:0]         self_state;
  logic               move_left;
  logic               move_right;
  logic               attack;
  logic [1:0]         ai_state;

  // master: the controller issuing commands
  modport master (
    input  enable, opp_x, opp_state,
    input  self_x, self_state,
    output move_left, move_right, attack,
    output ai_state
  );

  // slave: the game side consuming commands
  modport slave (
    output enable, opp_x, opp_state,
    output self_x, self_state,
    input  move_left, move_right, attack,
    input  ai_state
  );

endinterface

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
// Ports: clk, reset (async low), enable, o_value.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] o_value
);

  // All-zero is the lock-up state.
  localparam logic [7:0] L_SEED =
    (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] r_q;
  logic       w_fb;

  assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_q <= L_SEED;
    else if (enable)
      r_q <= {r_q[6:0], w_fb};
  end

  assign o_value = r_q;

endmodule

// File: rtl/cpu_opponent.sv
// Autonomous character-2 controller: WAIT/DECIDE/ACT/COOLDOWN.
// Ports: clk, reset (async low), io (cpu_opponent_if.master).
module cpu_opponent
  import footies_pkg::*;
#(
  parameter int         REACT_CYCLES    = 4,
  parameter int         HOLD_CYCLES     = 3,
  parameter int         COOLDOWN_CYCLES = 8,
  parameter int         ATTACK_RANGE    = 40,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic           clk,
  input  logic           reset,
  cpu_opponent_if.master io
);

  localparam logic [7:0] L_REACT_END =
    8'(REACT_CYCLES - 1);
  localparam logic [7:0] L_HOLD_END =
    8'(HOLD_CYCLES - 1);
  localparam logic [7:0] L_COOL_END =
    8'(COOLDOWN_CYCLES - 1);
  localparam logic [COORD_W-1:0] L_RANGE =
    COORD_W'(ATTACK_RANGE);

  ai_state_e          r_state;
  logic [7:0]         r_cnt;
  logic               r_ml;
  logic               r_mr;
  logic               r_atk;

  logic [7:0]         w_lfsr;
  logic [COORD_W-1:0] w_dist;
  logic               w_in_range;
  logic               w_opp_atk;
  logic               w_hit;
  logic               w_retreat;
  logic               w_strike;
  logic               w_feint;
  logic               w_approach;
  logic               w_unused;

  lfsr8 #(
    .SEED    (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .enable  (io.enable),
    .o_value (w_lfsr)
  );

  assign w_unused = ^w_lfsr[7:1];

  assign w_dist     = sat_dist(io.self_x, io.opp_x);
  assign w_in_range = (w_dist <= L_RANGE);
  assign w_hit      = (io.self_state == HITSTUN);
  assign w_opp_atk  = (io.opp_state == ATTACK_START) ||
                      (io.opp_state == ATTACK_ACTIVE);

  // Priority chain flattened into exclusive terms.
  assign w_retreat  = !w_hit && w_opp_atk && w_in_range;
  assign w_strike   = !w_hit && !w_opp_atk &&
                      w_in_range && w_lfsr[0];
  assign w_feint    = !w_hit && !w_opp_atk &&
                      w_in_range && !w_lfsr[0];
  assign w_approach = !w_hit && !w_in_range;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= AI_WAIT;
      r_cnt   <= '0;
      r_ml    <= 1'b0;
      r_mr    <= 1'b0;
      r_atk   <= 1'b0;
    end else if (!io.enable) begin
      r_state <= AI_WAIT;
      r_cnt   <= '0;
      r_ml    <= 1'b0;
      r_mr    <= 1'b0;
      r_atk   <= 1'b0;
    end else begin
      unique case (r_state)
        AI_WAIT: begin
          if (r_cnt == L_REACT_END) begin
            r_state <= AI_DECIDE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        AI_DECIDE: begin
          r_cnt <= '0;
          r_ml  <= 1'b0;
          r_mr  <= 1'b0;
          r_atk <= 1'b0;
          unique case (1'b1)
            w_hit:      r_state <= AI_WAIT;
            w_retreat: begin
              r_mr    <= 1'b1;
              r_state <= AI_ACT;
            end
            w_strike: begin
              r_atk   <= 1'b1;
              r_state <= AI_ACT;
            end
            w_feint:    r_state <= AI_WAIT;
            w_approach: begin
              r_ml    <= 1'b1;
              r_state <= AI_ACT;
            end
            default:    r_state <= AI_WAIT;
          endcase
        end
        AI_ACT: begin
          if (w_hit) begin
            // Getting hit cancels any command.
            r_state <= AI_WAIT;
            r_cnt   <= '0;
            r_ml    <= 1'b0;
            r_mr    <= 1'b0;
            r_atk   <= 1'b0;
          end else if (r_atk) begin
            r_state <= AI_COOLDOWN;
            r_cnt   <= '0;
            r_atk   <= 1'b0;
          end else if (r_cnt == L_HOLD_END) begin
            r_state <= AI_WAIT;
            r_cnt   <= '0;
            r_ml    <= 1'b0;
            r_mr    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        AI_COOLDOWN: begin
          if (r_cnt == L_COOL_END) begin
            r_state <= AI_WAIT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= AI_WAIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign io.move_left  = r_ml;
  assign io.move_right = r_mr;
  assign io.attack     = r_atk;
  assign io.ai_state   = r_state;

endmodule

// File: tb/tb_cpu_opponent.sv
// Self-checking bench for cpu_opponent: vector table,
// directed corner sequences and a schedule-based model.
module tb_cpu_opponent;
  import footies_pkg::*;

  localparam int REACT = 4;
  localparam int HOLD  = 3;
  localparam int COOL  = 8;
  localparam int RANGE = 40;

  typedef struct packed {
    logic       ml;
    logic       mr;
    logic       atk;
    logic [1:0] st;
  } exp_t;

  typedef struct {
    logic [9:0] ox;
    logic [9:0] sx;
    logic [2:0] os;
    logic [2:0] ss;
    exp_t       e;
  } vec_t;

  localparam exp_t E_W  = '{1'b0, 1'b0, 1'b0, 2'd0};
  localparam exp_t E_D  = '{1'b0, 1'b0, 1'b0, 2'd1};
  localparam exp_t E_ML = '{1'b1, 1'b0, 1'b0, 2'd2};
  localparam exp_t E_MR = '{1'b0, 1'b1, 1'b0, 2'd2};
  localparam exp_t E_AT = '{1'b0, 1'b0, 1'b1, 2'd2};
  localparam exp_t E_CD = '{1'b0, 1'b0, 1'b0, 2'd3};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  cpu_opponent_if bi ();

  cpu_opponent #(
    .REACT_CYCLES    (REACT),
    .HOLD_CYCLES     (HOLD),
    .COOLDOWN_CYCLES (COOL),
    .ATTACK_RANGE    (RANGE),
    .LFSR_SEED       (8'hA5)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .io    (bi.master)
  );

  always #5 clk = ~clk;

  // Model: upcoming per-tick outputs as a queue.
  exp_t       q[$];
  exp_t       cur;
  logic [7:0] m_lfsr;
  int         m_dec;
  vec_t       tbl[16];

  function automatic logic [7:0] lfsr_nx(
    input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic push_n(input exp_t e, input int n);
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  task automatic sched_wait();
    push_n(E_W, REACT - 1);
    push_n(E_D, 1);
  endtask

  task automatic model_reset();
    q.delete();
    cur    = E_W;
    m_lfsr = 8'hA5;
    sched_wait();
  endtask

  task automatic model_step();
    int d;
    bit inr;
    if (!bi.enable) begin
      q.delete();
      cur = E_W;
      sched_wait();
      return;
    end
    d   = int'(bi.self_x) - int'(bi.opp_x);
    inr = (d <= RANGE);
    if (cur.st == 2'd2 && bi.self_state == 3'd6) begin
      q.delete();
      cur = E_W;
      sched_wait();
    end else if (q.size() == 0) begin
      m_dec++;
      q.delete();
      if (bi.self_state == 3'd6) begin
        cur = E_W;
        sched_wait();
      end else if (inr && (bi.opp_state == 3'd3 ||
                           bi.opp_state == 3'd4)) begin
        cur = E_MR;
        push_n(E_MR, HOLD - 1);
        push_n(E_W, 1);
        sched_wait();
      end else if (inr && m_lfsr[0]) begin
        cur = E_AT;
        push_n(E_CD, COOL);
        push_n(E_W, 1);
        sched_wait();
      end else if (inr) begin
        cur = E_W;
        sched_wait();
      end else begin
        cur = E_ML;
        push_n(E_ML, HOLD - 1);
        push_n(E_W, 1);
        sched_wait();
      end
    end else begin
      cur = q.pop_front();
    end
    m_lfsr = lfsr_nx(m_lfsr);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               nm, got, want);
    end
  endtask

  function automatic exp_t dut_out();
    return {bi.move_left, bi.move_right,
            bi.attack, bi.ai_state};
  endfunction

  // One clock; returns at the following negedge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    chk("model", dut_out(), cur);
    chk("onehot",
        32'($countones({bi.move_left, bi.move_right,
                        bi.attack}) <= 1), 1);
  endtask

  task automatic set_in(input int ox, input int sx,
                        input int os, input int ss);
    bi.opp_x      = 10'(ox);
    bi.self_x     = 10'(sx);
    bi.opp_state  = 3'(os);
    bi.self_state = 3'(ss);
  endtask

  task automatic run_dec(input int n);
    int s;
    s = m_dec;
    for (int k = 0; k < n * 20 && m_dec - s < n; k++)
      tick();
    chk("decisions", m_dec - s, n);
  endtask

  task automatic wait_ml_act();
    for (int k = 0; k < 40 && cur != E_ML; k++)
      tick();
    chk("reach ml act", dut_out(), E_ML);
  endtask

  initial begin
    int   n_atk;
    int   last_rise;
    int   t;
    logic prev_atk;

    for (int i = 0; i < 16; i++) begin
      tbl[i].ox = (i >= 8) ? 10'd270 : 10'd100;
      tbl[i].sx = 10'd300;
      tbl[i].os = (i >= 8) ? 3'd4 : 3'd0;
      tbl[i].ss = 3'd0;
    end
    tbl[0].e  = E_W;  tbl[1].e  = E_W;
    tbl[2].e  = E_W;  tbl[3].e  = E_D;
    tbl[4].e  = E_ML; tbl[5].e  = E_ML;
    tbl[6].e  = E_ML; tbl[7].e  = E_W;
    tbl[8].e  = E_W;  tbl[9].e  = E_W;
    tbl[10].e = E_W;  tbl[11].e = E_D;
    tbl[12].e = E_MR; tbl[13].e = E_MR;
    tbl[14].e = E_MR; tbl[15].e = E_W;

    m_dec     = 0;
    bi.enable = 1'b1;
    set_in(100, 300, 0, 0);
    model_reset();

    // Held in reset: everything idle.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset idle", dut_out(), E_W);
    end
    rst = 1'b1;

    // Approach then retreat, per-edge table.
    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].ox, tbl[i].sx,
             tbl[i].os, tbl[i].ss);
      tick();
      chk($sformatf("vec%0d", i), dut_out(), tbl[i].e);
    end

    // Attack / feint at dist 30.
    set_in(100, 130, 0, 0);
    n_atk     = 0;
    last_rise = -100;
    prev_atk  = 1'b0;
    t         = 0;
    begin
      int s;
      s = m_dec;
      for (int k = 0; k < 64 * 20 && m_dec - s < 64; k++) begin
        tick();
        t++;
        if (bi.attack && prev_atk)
          chk("attack width", 2, 1);
        if (bi.attack && !prev_atk) begin
          n_atk++;
          if (last_rise >= 0)
            chk("attack spacing",
                32'(t - last_rise >= 14), 1);
          last_rise = t;
        end
        prev_atk = bi.attack;
      end
      chk("64 decisions", m_dec - s, 64);
    end
    chk("attack count",
        32'(n_atk >= 16 && n_atk <= 48), 1);

    // Hitstun abort during move, then DECIDE in hitstun.
    run_dec(1);
    set_in(100, 300, 0, 0);
    wait_ml_act();
    bi.self_state = 3'd6;
    tick();
    chk("hit abort", dut_out(), E_W);
    for (int k = 0; k < 20 && cur != E_D; k++)
      tick();
    chk("hit reach decide", dut_out(), E_D);
    tick();
    chk("hit decide", dut_out(), E_W);
    bi.self_state = 3'd0;

    // Enable low mid-ACT; LFSR must stay frozen.
    wait_ml_act();
    bi.enable = 1'b0;
    tick();
    chk("enable off", dut_out(), E_W);
    for (int i = 0; i < 5; i++) tick();
    bi.enable = 1'b1;
    set_in(100, 130, 0, 0);
    run_dec(10);

    // Async reset mid-ACT.
    set_in(100, 300, 0, 0);
    wait_ml_act();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async reset", dut_out(), E_W);
    tick();
    tick();
    rst = 1'b1;
    set_in(100, 130, 0, 0);
    run_dec(10);

    // Crossover: dist saturates to 0, in range.
    set_in(100, 90, 0, 0);
    begin
      int s;
      s = m_dec;
      for (int k = 0; k < 300 && m_dec - s < 10; k++) begin
        tick();
        chk("crossover no move",
            {bi.move_left, bi.move_right}, 0);
      end
      chk("crossover decisions", m_dec - s, 10);
    end

    // Random stimulus.
    for (int i = 0; i < 10000; i++) begin
      int ox;
      int sx;
      int ss;
      ox = $urandom_range(0, 900);
      sx = ox + $urandom_range(0, 100) - 20;
      if (sx < 0) sx = 0;
      ss = $urandom_range(0, 5);
      if ($urandom_range(0, 7) == 0) ss = 6;
      set_in(ox, sx, $urandom_range(0, 7), ss);
      bi.enable = ($urandom_range(0, 49) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_opponent.md
# cpu_opponent

Autonomous controller for character 2: the command-generating end of the character FSM input interface (move_left / move_right / attack). It observes both characters' positions and FSM states and emits one-hot, registered commands on the game tick. In the top level it replaces the fixed, idle character 2 and feeds a second `fsm` instance.

## Interface
- REACT_CYCLES, 4: ticks spent in WAIT before each decision (≥1)
- HOLD_CYCLES, 3: ticks a move command is held (≥1)
- COOLDOWN_CYCLES, 8: ticks of forced idle after an attack (≥1)
- ATTACK_RANGE, 40: distance in px at or below which the opponent is "in range"
- LFSR_SEED, 8'hA5: LFSR reset value; 8'h00 is replaced by 8'h01
- clk  in  1  game tick (selected_clk in the top level)
- reset  in  1  asynchronous, active-low; clears all state while low
- enable  in  1  high = controller runs; low = outputs idle
- opp_x  in  10  character 1 x position
- opp_state  in  3  character 1 FSM state
- self_x  in  10  character 2 x position
- self_state  in  3  character 2 FSM state
- move_left  out  1  approach command (character 2 faces left)
- move_right  out  1  retreat command
- attack  out  1  attack command, single-tick pulse
- ai_state  out  2  current controller state, for HEX/LED debug

## Operation
- Distance: dist = self_x − opp_x as 10-bit unsigned, saturated to 0 when self_x < opp_x (crossover counts as in range).
- States: WAIT=0, DECIDE=1, ACT=2, COOLDOWN=3. Shared counter cnt, 8 bits.
- WAIT: outputs 0; cnt increments; at cnt==REACT_CYCLES−1 → DECIDE, cnt←0.
- DECIDE (one tick), priority order, inputs sampled this tick:
  - self_state==HITSTUN → no command, → WAIT.
  - opp_state ∈ {ATTACK_START, ATTACK_ACTIVE} and dist ≤ ATTACK_RANGE → move_right←1, → ACT.
  - dist ≤ ATTACK_RANGE and lfsr[0]==1 → attack←1, → ACT.
  - dist ≤ ATTACK_RANGE and lfsr[0]==0 → feint: no command, → WAIT.
  - dist > ATTACK_RANGE → move_left←1, → ACT.
- ACT: command held; move commands end at cnt==HOLD_CYCLES−1 (outputs←0, → WAIT); an attack ends after one tick (attack←0, → COOLDOWN, cnt←0).
- COOLDOWN: outputs 0; at cnt==COOLDOWN_CYCLES−1 → WAIT, cnt←0.
- self_state becomes HITSTUN while in ACT → outputs←0 and → WAIT on that edge, cnt←0; overrides normal ACT exit.
- enable low: on the next edge outputs←0, state←WAIT, cnt←0; LFSR frozen.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, advances every tick while enable is high.
- Invariant: at most one of move_left, move_right, attack is high on any tick.

## Timing
- Reset value of every output is 0; ai_state=WAIT; cnt=0; lfsr=LFSR_SEED (or 8'h01).
- All outputs are registered; none depends combinationally on any input.
- Reset deassertion is followed by REACT_CYCLES WAIT ticks, then 1 DECIDE tick. The first command is visible after edge REACT_CYCLES+1.
- Move command width is exactly HOLD_CYCLES ticks. Attack width is exactly 1 tick.
- Minimum spacing between the rising ticks of two attacks is 1+COOLDOWN_CYCLES+REACT_CYCLES+1 = 14 with defaults.
- Asserting reset mid-ACT clears outputs immediately, without waiting for a clock edge.

## Structure
- Shared package `footies_pkg` holds:
  - character state encodings: IDLE=0, MOVE_FWD=1, MOVE_BACK=2, ATTACK_START=3, ATTACK_ACTIVE=4, ATTACK_RECOVERY=5, HITSTUN=6, BLOCK=7
  - the ai_state encodings
  - the 10-bit coordinate width
- One sub-module: `lfsr8`, with inputs clk, reset, enable and a SEED parameter, outputting an 8-bit value.

## Test plan
- Reset and approach: opp_x=100, self_x=300, both IDLE, release reset → move_left high exactly 3 ticks starting after edge 5, then ai_state=WAIT; all outputs 0 while reset is low.
- Retreat: opp_x=270, self_x=300, opp_state=ATTACK_ACTIVE → move_right high 3 ticks after DECIDE; move_left and attack stay 0.
- Attack and feint: dist=30, opp IDLE, run 64 decisions:
  - every attack is a 1-tick pulse;
  - attack rising edges are ≥14 ticks apart;
  - attack count is 16–48;
  - the sequence matches a bench LFSR model seeded 8'hA5.
- Hitstun abort: during a move_left ACT, drive self_state=HITSTUN → move_left is 0 on the next tick and ai_state=WAIT; DECIDE with HITSTUN issues no command.
- Enable and mid-op reset:
  - enable low during ACT → outputs 0 on the next edge, LFSR value unchanged;
  - reset pulsed low mid-ACT → outputs 0 immediately and the LFSR reloads its seed.
- Crossover and exclusivity: self_x=90, opp_x=100 → dist=0 is treated as in range (attack or feint only). Random x/state stimulus for 10k ticks never raises two outputs at once.
